pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM receiver that recovers the duty-cycle code from a single-wire PWM signal, the counterpart of the duty-ramp/PWM transmitter. It samples `pwm_in` on the system clock, measures high time over each rising-edge-to-rising-edge frame, and reports a saturated duty code with a one-cycle valid strobe. It also flags ramp end points (top/bottom reached), frame-length errors and stuck-line conditions. It sits at a loopback/observation point so a consumer can check or track the transmitter's ramp.

## Interface
- `PERIOD`, 16: nominal frame length in clk cycles.
- `DUTY_W`, 4: duty code width; max code `DMAX` = 2^DUTY_W-1.
- `TIMEOUT`, 2*PERIOD: cycles without a rising edge before the line is declared stuck.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pwm_in` in 1: PWM line, asynchronous to `clk` when synchronizer is compiled in.
- `duty_cycle` out DUTY_W: last measured duty code, held between reports.
- `duty_valid` out 1: one-cycle strobe, `duty_cycle` updated this cycle.
- `ready` out 1: one-cycle strobe, report reached `DMAX` from a lower value.
- `ready_d` out 1: one-cycle strobe, report reached 0 from a higher value.
- `period_err` out 1: one-cycle strobe with `duty_valid`, measured frame length != `PERIOD`.
- `stuck` out 1: level, high while in STUCK state.

## Operation
- `s` = conditioned line (synchronized or raw), `s_d` = `s` delayed one cycle; `rise` = `s & ~s_d`, `fall` = `~s & s_d`.
- `hi_cnt`: cycles with `s`=1 since last rise, rise cycle included. `per_cnt`: cycles since last rise, rise cycle included. Both saturate at `TIMEOUT`; width clog2(TIMEOUT+1).
- States:
  - IDLE (reset state): `per_cnt` counts. On `rise`, go to MEASURE with `hi_cnt`=1, `per_cnt`=1 and no report. When `per_cnt` hits `TIMEOUT`, issue a stuck report and go to STUCK.
  - MEASURE: on `rise`, report `duty_cycle` = min(`hi_cnt`, DMAX). Pulse `period_err` if `per_cnt` != `PERIOD`. Restart counters at 1 and stay. When `per_cnt` hits `TIMEOUT` without a rise, issue a stuck report and go to STUCK.
  - STUCK: `stuck`=1. On `rise`, go to MEASURE with counters at 1 and no report. On `fall`, go to IDLE with counters cleared.
- Stuck report: `duty_cycle` = `s` ? DMAX : 0, with `duty_valid`. `period_err` is not asserted.
- Ramp flags are evaluated on every report against the previously reported code `prev`:
  - `ready` = (new == DMAX) && (prev < DMAX).
  - `ready_d` = (new == 0) && (prev > 0).
  - `prev` resets to 0, so a first report of 0 gives no `ready_d`.
- Reset, including mid-frame: state IDLE, all counters 0, `prev` 0, `s`/`s_d` and synchronizer flops 0. Every output is 0 in the cycle after `rst` is sampled high.

## Timing
- All outputs are registered. Strobes are exactly one cycle wide. `duty_cycle` holds its value between strobes.
- Latency from the first clk edge sampling `pwm_in` high to `duty_valid`=1: 3 cycles with synchronizer, 1 without.
- The first report needs two rising edges after reset. Reports then occur once per frame, every `PERIOD` cycles for a nominal signal.
- A rise on the same cycle `per_cnt` would hit `TIMEOUT` is taken as a rise. The rise has priority over the timeout.
- A high time of `PERIOD` or more saturates to DMAX.

## Configuration
- `PWM_CAP_SYNC_EN` defined: `pwm_in` passes through a 2-flop synchronizer before `s`. Latency is 3 cycles.
- `PWM_CAP_SYNC_EN` undefined: `s` samples `pwm_in` directly, which must then be `clk`-synchronous. Latency is 1 cycle. All other behaviour is identical.

## Structure
- Package `pwm_pkg` holds the `PERIOD`/`DUTY_W` defaults shared with the transmitter, the state enum (IDLE, MEASURE, STUCK) and the `DMAX` constant.
- Sub-module `pwm_edge_sync` contains the optional synchronizer and the `s_d`/`rise`/`fall` generation. Counters, FSM and report logic stay in `pwm_capture`.

## Test plan
- Nominal 16-cycle frames, high 5: `duty_valid` pulses every 16 cycles with `duty_cycle`=5 and `period_err`=0. First report 3 cycles after the second rise (synchronizer on).
- Ramp 0→15→0, one frame per step, driven by the companion transmitter: `ready` pulses once on the report of 15 and `ready_d` once on the return to 0. Codes are monotonic with no gaps.
- Line held low from reset: after 32 cycles, one report with `duty_cycle`=0, `stuck`=1, `ready_d`=0. Then drive frames of duty 3: `stuck` drops on the rise and the next report is 3.
- From a report of 9, hold the line high for 40 cycles: report 15 with `ready`=1 and `stuck`=1. A following fall sends the block to IDLE and gives a 0 report after 32 cycles with `ready_d`=1.
- A 20-cycle frame with high 7: report 7 with `period_err`=1.
- Assert `rst` mid-frame: all outputs 0 next cycle. The next report needs two fresh rises. `prev`=0, so an immediate 0 report gives no `ready_d`.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM link constants (common with the duty-ramp transmitter) and
// the receiver state encoding.
package pwm_pkg;

    localparam int unsigned PWM_PERIOD = 16;
    localparam int unsigned PWM_DUTY_W = 4;
    localparam int unsigned DMAX       = (1 << PWM_DUTY_W) - 1;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STUCK
    } cap_state_t;

    function automatic int unsigned sat_code(int unsigned cnt, int unsigned dmax);
        return (cnt > dmax) ? dmax : cnt;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Line conditioning for pwm_capture: optional 2-flop synchronizer
// (PWM_CAP_SYNC_EN), one-cycle delayed copy and rise/fall detection.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic line_c;
    logic s_d;

`ifdef PWM_CAP_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
        end
    end

    assign line_c = sync_q[1];
`else
    assign line_c = pwm_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s   <= line_c;
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time per rise-to-rise frame and reports a
// saturated duty code, ramp end points, frame errors and stuck line.
// Define PWM_CAP_SYNC_EN to insert a 2-flop input synchronizer.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD  = PWM_PERIOD,
    parameter int unsigned DUTY_W  = PWM_DUTY_W,
    parameter int unsigned TIMEOUT = 2 * PERIOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              duty_valid,
    output logic              ready,
    output logic              ready_d,
    output logic              period_err,
    output logic              stuck
);

    localparam int unsigned       CW     = $clog2(TIMEOUT + 1);
    localparam int unsigned       DMAX_C = (DUTY_W == PWM_DUTY_W) ? DMAX : ((1 << DUTY_W) - 1);
    localparam logic [CW-1:0]     TO_C   = CW'(TIMEOUT);
    localparam logic [CW-1:0]     PER_C  = CW'(PERIOD);
    localparam logic [CW-1:0]     ONE_C  = CW'(1);
    localparam logic [DUTY_W-1:0] DMAX_V = DUTY_W'(DMAX_C);

    logic s, rise, fall;

    cap_state_t        state_q, state_d;
    logic [CW-1:0]     hi_cnt, per_cnt;
    logic [CW-1:0]     hi_d, per_d, hi_inc, per_inc;
    logic              timeout;
    logic              rep, rep_perr, rep_ready, rep_ready_d;
    logic [DUTY_W-1:0] rep_code;

    pwm_edge_sync u_edge (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        per_inc  = (per_cnt == TO_C) ? TO_C : per_cnt + ONE_C;
        hi_inc   = (s && hi_cnt != TO_C) ? hi_cnt + ONE_C : hi_cnt;
        timeout  = (per_inc == TO_C);
        state_d  = state_q;
        hi_d     = hi_cnt;
        per_d    = per_cnt;
        rep      = 1'b0;
        rep_perr = 1'b0;
        rep_code = duty_cycle;

        case (state_q)
            IDLE: begin
                hi_d  = '0;
                per_d = per_inc;
                if (rise) begin
                    state_d = MEASURE;
                    hi_d    = ONE_C;
                    per_d   = ONE_C;
                end else if (timeout) begin
                    state_d  = STUCK;
                    rep      = 1'b1;
                    rep_code = s ? DMAX_V : '0;
                end
            end
            MEASURE: begin
                hi_d  = hi_inc;
                per_d = per_inc;
                // Rise wins over a simultaneous timeout.
                if (rise) begin
                    rep      = 1'b1;
                    rep_code = DUTY_W'(sat_code(32'(hi_cnt), DMAX_C));
                    rep_perr = (per_cnt != PER_C);
                    hi_d     = ONE_C;
                    per_d    = ONE_C;
                end else if (timeout) begin
                    state_d  = STUCK;
                    rep      = 1'b1;
                    rep_code = s ? DMAX_V : '0;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d = MEASURE;
                    hi_d    = ONE_C;
                    per_d   = ONE_C;
                end else if (fall) begin
                    state_d = IDLE;
                    hi_d    = '0;
                    per_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // duty_cycle always holds the previous report, so it doubles as prev.
        rep_ready   = rep && (rep_code == DMAX_V) && (duty_cycle != DMAX_V);
        rep_ready_d = rep && (rep_code == '0) && (duty_cycle != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt     <= '0;
            per_cnt    <= '0;
            duty_cycle <= '0;
            duty_valid <= 1'b0;
            ready      <= 1'b0;
            ready_d    <= 1'b0;
            period_err <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            hi_cnt     <= hi_d;
            per_cnt    <= per_d;
            duty_cycle <= rep_code;
            duty_valid <= rep;
            ready      <= rep_ready;
            ready_d    <= rep_ready_d;
            period_err <= rep_perr;
            stuck      <= (state_d == STUCK);
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: cycle-level reference model of the frame rules
// plus directed scenarios with literal expectations on the report log.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int PERIOD  = 16;
    localparam int DUTY_W  = 4;
    localparam int TIMEOUT = 32;
    localparam int DMAX    = 15;
`ifdef PWM_CAP_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic              pwm_in = 1'b0;
    logic [DUTY_W-1:0] duty_cycle;
    logic              duty_valid, ready, ready_d, period_err, stuck;

    pwm_capture #(
        .PERIOD  (PERIOD),
        .DUTY_W  (DUTY_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_cycle (duty_cycle),
        .duty_valid (duty_valid),
        .ready      (ready),
        .ready_d    (ready_d),
        .period_err (period_err),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic void check(string name, int act, int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, want);
        end
    endfunction

    // ---------------- reference model ----------------
    bit armed = 0;
    bit s_now = 0, s_prev = 0;
    bit dq[$];       // input delay ahead of the conditioned line
    bit frame[$];    // conditioned line samples since the frame anchor
    bit measuring = 0, in_stuck = 0;
    int last_code = 0;
    int e_code = 0, e_valid = 0, e_ready = 0, e_ready_d = 0, e_perr = 0, e_stuck = 0;
    int n_code = 0, n_valid = 0, n_ready = 0, n_ready_d = 0, n_perr = 0, n_stuck = 0;

    function automatic void model_report(int code, bit perr);
        n_valid   = 1;
        n_code    = code;
        n_perr    = perr;
        n_ready   = (code == DMAX && last_code < DMAX);
        n_ready_d = (code == 0 && last_code > 0);
        last_code = code;
    endfunction

    always @(posedge clk) begin
        int ones;
        bit rise, fall;
        cyc++;
        if (rst) begin
            armed = 1;
            dq.delete();
            for (int i = 0; i < LAT - 1; i++) dq.push_back(1'b0);
            s_prev = 0; s_now = 0;
            frame.delete();
            measuring = 0; in_stuck = 0; last_code = 0;
            e_code = 0; e_valid = 0; e_ready = 0; e_ready_d = 0; e_perr = 0; e_stuck = 0;
        end else begin
            e_code = n_code; e_valid = n_valid; e_ready = n_ready;
            e_ready_d = n_ready_d; e_perr = n_perr; e_stuck = n_stuck;
            s_prev = s_now;
            dq.push_back(pwm_in);
            s_now = dq.pop_front();
        end
        rise = s_now & ~s_prev;
        fall = ~s_now & s_prev;
        n_valid = 0; n_ready = 0; n_ready_d = 0; n_perr = 0; n_code = last_code;
        ones = 0;
        foreach (frame[i]) ones += frame[i];
        if (in_stuck) begin
            if (rise) begin
                in_stuck = 0; measuring = 1;
                frame.delete(); frame.push_back(1'b1);
            end else if (fall) begin
                in_stuck = 0; measuring = 0;
                frame.delete();
            end
        end else if (rise) begin
            if (measuring) model_report((ones < DMAX) ? ones : DMAX, frame.size() != PERIOD);
            measuring = 1;
            frame.delete(); frame.push_back(1'b1);
        end else if (frame.size() == TIMEOUT - 1) begin
            model_report(s_now ? DMAX : 0, 1'b0);
            in_stuck = 1;
        end else begin
            frame.push_back(s_now);
        end
        n_stuck = in_stuck;
    end

    // ---------------- per-cycle compare and report log ----------------
    typedef struct {
        int cyc;
        int code;
        bit rdy;
        bit rdyd;
        bit perr;
        bit stk;
    } rep_t;
    rep_t reps[$];

    always @(negedge clk) begin
        if (armed) begin
            check("duty_cycle", duty_cycle, e_code);
            check("duty_valid", duty_valid, e_valid);
            check("ready",      ready,      e_ready);
            check("ready_d",    ready_d,    e_ready_d);
            check("period_err", period_err, e_perr);
            check("stuck",      stuck,      e_stuck);
            if (duty_valid)
                reps.push_back('{cyc, int'(duty_cycle), ready, ready_d, period_err, stuck});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; pwm_in = 0;
        tick(2);
        rst = 0;
        reps.delete();
    endtask

    task automatic drive_frame(int p, int h);
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < h);
            tick(1);
        end
    endtask

    task automatic hold(bit lvl, int n);
        pwm_in = lvl;
        tick(n);
    endtask

    initial begin
        int t2, r0, nr, nrd, idx;
        int exp_codes[$];

        // A: nominal frames, high 5
        do_reset();
        drive_frame(PERIOD, 5);
        t2 = cyc + 1;
        repeat (4) drive_frame(PERIOD, 5);
        check("A_count", reps.size(), 4);
        if (reps.size() > 0) check("A_latency", reps[0].cyc - t2, LAT);
        for (int i = 0; i < reps.size(); i++) begin
            check("A_code", reps[i].code, 5);
            check("A_perr", reps[i].perr, 0);
            if (i > 0) check("A_interval", reps[i].cyc - reps[i-1].cyc, PERIOD);
        end

        // B: ramp up and down, then line low
        do_reset();
        for (int k = 1; k <= 15; k++) drive_frame(PERIOD, k);
        for (int k = 14; k >= 1; k--) drive_frame(PERIOD, k);
        hold(0, 40);
        for (int k = 1; k <= 15; k++) exp_codes.push_back(k);
        for (int k = 14; k >= 2; k--) exp_codes.push_back(k);
        exp_codes.push_back(0);
        check("B_count", reps.size(), exp_codes.size());
        nr = 0; nrd = 0; idx = -1;
        for (int i = 0; i < reps.size(); i++) begin
            if (i < exp_codes.size()) check("B_code", reps[i].code, exp_codes[i]);
            nr  += reps[i].rdy;
            nrd += reps[i].rdyd;
            if (reps[i].rdy) idx = i;
        end
        check("B_ready_cnt", nr, 1);
        check("B_ready_d_cnt", nrd, 1);
        if (idx >= 0) check("B_ready_code", reps[idx].code, 15);
        if (reps.size() > 0) check("B_last_ready_d", reps[reps.size()-1].rdyd, 1);

        // C: low from reset, then duty-3 frames
        do_reset();
        r0 = cyc;
        hold(0, 40);
        check("C_count", reps.size(), 1);
        if (reps.size() > 0) begin
            check("C_code", reps[0].code, 0);
            check("C_stuck", reps[0].stk, 1);
            check("C_ready_d", reps[0].rdyd, 0);
            check("C_time", reps[0].cyc - r0, 32);
        end
        reps.delete();
        repeat (3) drive_frame(PERIOD, 3);
        check("C2_count", reps.size(), 2);
        if (reps.size() > 0) begin
            check("C2_code", reps[0].code, 3);
            check("C2_stuck", reps[0].stk, 0);
        end

        // D: from code 9, stuck high then stuck low
        do_reset();
        repeat (3) drive_frame(PERIOD, 9);
        reps.delete();
        hold(1, 40);
        hold(0, 40);
        check("D_count", reps.size(), 3);
        if (reps.size() == 3) begin
            check("D_code0", reps[0].code, 9);
            check("D_code1", reps[1].code, 15);
            check("D_ready1", reps[1].rdy, 1);
            check("D_stuck1", reps[1].stk, 1);
            check("D_perr1", reps[1].perr, 0);
            check("D_code2", reps[2].code, 0);
            check("D_ready_d2", reps[2].rdyd, 1);
        end

        // E: long frame flags period_err
        do_reset();
        drive_frame(PERIOD, 5);
        drive_frame(20, 7);
        drive_frame(PERIOD, 5);
        drive_frame(PERIOD, 5);
        check("E_count", reps.size(), 3);
        if (reps.size() == 3) begin
            check("E_perr0", reps[0].perr, 0);
            check("E_code1", reps[1].code, 7);
            check("E_perr1", reps[1].perr, 1);
            check("E_code2", reps[2].code, 5);
        end

        // F: mid-frame resets
        do_reset();
        repeat (3) drive_frame(PERIOD, 9);
        hold(1, 3);
        rst = 1;
        tick(1);
        check("F_rst_code", duty_cycle, 0);
        check("F_rst_valid", duty_valid, 0);
        check("F_rst_ready", ready, 0);
        check("F_rst_ready_d", ready_d, 0);
        check("F_rst_perr", period_err, 0);
        check("F_rst_stuck", stuck, 0);
        rst = 0;
        reps.delete();
        repeat (3) drive_frame(PERIOD, 6);
        check("F_count", reps.size(), 2);
        if (reps.size() > 0) check("F_code", reps[0].code, 6);
        hold(1, 3);
        rst = 1;
        tick(1);
        rst = 0;
        reps.delete();
        hold(0, 40);
        check("F2_count", reps.size(), 1);
        if (reps.size() > 0) begin
            check("F2_code", reps[0].code, 0);
            check("F2_ready_d", reps[0].rdyd, 0);
            check("F2_stuck", reps[0].stk, 1);
        end

        // Random frames, odd periods, holds and resets against the model
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int r, p;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                drive_frame(PERIOD, $urandom_range(0, PERIOD));
            end else if (r < 8) begin
                p = $urandom_range(10, 24);
                drive_frame(p, $urandom_range(0, p));
            end else if (r == 8) begin
                hold(1'($urandom_range(0, 1)), $urandom_range(20, 45));
            end else begin
                pwm_in = 1'($urandom_range(0, 1));
                rst = 1;
                tick(1);
                rst = 0;
            end
        end
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
